// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I controller: FSM states, opcodes and
// the datapath mux / ALU select codes.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRead,
    StMemWb,
    StMemWrite,
    StExecuteR,
    StExecuteI,
    StAluWb,
    StJal,
    StBranch,
    StTrap
  } state_t;

  localparam logic [6:0] OpRtype  = 7'b0110011;
  localparam logic [6:0] OpItype  = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;
  localparam logic [2:0] AluSlt = 3'b101;

  localparam logic [1:0] AluOpAdd   = 2'b00;
  localparam logic [1:0] AluOpSub   = 2'b01;
  localparam logic [1:0] AluOpFunct = 2'b10;

  localparam logic [1:0] ImmI = 2'b00;
  localparam logic [1:0] ImmS = 2'b01;
  localparam logic [1:0] ImmB = 2'b10;
  localparam logic [1:0] ImmJ = 2'b11;

  localparam logic [1:0] ResAluOut    = 2'b00;
  localparam logic [1:0] ResData      = 2'b01;
  localparam logic [1:0] ResAluResult = 2'b10;

  localparam logic [1:0] SrcAPc    = 2'b00;
  localparam logic [1:0] SrcAOldPc = 2'b01;
  localparam logic [1:0] SrcARs1   = 2'b10;

  localparam logic [1:0] SrcBRs2  = 2'b00;
  localparam logic [1:0] SrcBImm  = 2'b01;
  localparam logic [1:0] SrcBFour = 2'b10;

  // funct3 values the ALU can execute: ADD/SUB, SLT, OR, AND.
  function automatic logic funct3_alu_ok(logic [2:0] funct3);
    return (funct3 == 3'b000) || (funct3 == 3'b010) ||
           (funct3 == 3'b110) || (funct3 == 3'b111);
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU control decode from ALUOp and instruction fields.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       op_5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = AluAdd;
    case (alu_op)
      AluOpSub: alu_control = AluSub;
      AluOpFunct: begin
        case (funct3)
          // Only R-type (op_5) may select SUB; ADDI's imm[10] aliases funct7[5].
          3'b000:  alu_control = (op_5 && funct7_5) ? AluSub : AluAdd;
          3'b010:  alu_control = AluSlt;
          3'b110:  alu_control = AluOr;
          3'b111:  alu_control = AluAnd;
          default: alu_control = AluAdd;
        endcase
      end
      default: alu_control = AluAdd;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multicycle RV32I core: drives the shared datapath
// muxes and write enables through fetch/decode/execute/memory/writeback.
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter state_t RESET_STATE = StFetch
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [2:0]  ALUControl,
  output logic [1:0]  ImmSrc,
  output logic        RegWrite,
  output logic        retire,
  output logic        halted
);

  state_t     state_q, state_d;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [1:0] alu_op;
  logic       pc_write_raw, mem_write_raw, ir_write_raw, reg_write_raw;
  logic       retire_raw, halted_raw;
  logic       unused_instr;

  assign opcode       = instr[6:0];
  assign funct3       = instr[14:12];
  assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RESET_STATE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    pc_write_raw  = 1'b0;
    AdrSrc        = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    ResultSrc     = ResAluOut;
    ALUSrcA       = SrcAPc;
    ALUSrcB       = SrcBRs2;
    alu_op        = AluOpAdd;
    ImmSrc        = ImmI;
    reg_write_raw = 1'b0;
    retire_raw    = 1'b0;
    halted_raw    = 1'b0;

    unique case (state_q)
      StFetch: begin
        ALUSrcB      = SrcBFour;
        ResultSrc    = ResAluResult;
        ir_write_raw = mem_ready;
        pc_write_raw = mem_ready;
        if (mem_ready) state_d = StDecode;
      end
      StDecode: begin
        ALUSrcA = SrcAOldPc;
        ALUSrcB = SrcBImm;
        ImmSrc  = ImmB;
        state_d = StTrap;
        case (opcode)
          OpRtype: begin
            // funct7[5] is only meaningful for SUB.
            if (funct3_alu_ok(funct3) && !(instr[30] && funct3 != 3'b000)) begin
              state_d = StExecuteR;
            end
          end
          OpItype:         if (funct3_alu_ok(funct3)) state_d = StExecuteI;
          OpLoad, OpStore: if (funct3 == 3'b010) state_d = StMemAdr;
          OpBranch:        if (funct3[2:1] == 2'b00) state_d = StBranch;
          OpJal:           state_d = StJal;
          default:         state_d = StTrap;
        endcase
      end
      StMemAdr: begin
        ALUSrcA = SrcARs1;
        ALUSrcB = SrcBImm;
        ImmSrc  = (opcode == OpStore) ? ImmS : ImmI;
        state_d = (opcode == OpStore) ? StMemWrite : StMemRead;
      end
      StMemRead: begin
        AdrSrc = 1'b1;
        if (mem_ready) state_d = StMemWb;
      end
      StMemWb: begin
        ResultSrc     = ResData;
        reg_write_raw = 1'b1;
        retire_raw    = 1'b1;
        state_d       = StFetch;
      end
      StMemWrite: begin
        AdrSrc        = 1'b1;
        mem_write_raw = 1'b1;
        if (mem_ready) begin
          retire_raw = 1'b1;
          state_d    = StFetch;
        end
      end
      StExecuteR: begin
        ALUSrcA = SrcARs1;
        alu_op  = AluOpFunct;
        state_d = StAluWb;
      end
      StExecuteI: begin
        ALUSrcA = SrcARs1;
        ALUSrcB = SrcBImm;
        alu_op  = AluOpFunct;
        state_d = StAluWb;
      end
      StAluWb: begin
        reg_write_raw = 1'b1;
        retire_raw    = 1'b1;
        state_d       = StFetch;
      end
      StJal: begin
        ALUSrcA      = SrcAOldPc;
        ALUSrcB      = SrcBFour;
        ImmSrc       = ImmJ;
        pc_write_raw = 1'b1;
        state_d      = StAluWb;
      end
      StBranch: begin
        ALUSrcA      = SrcARs1;
        alu_op       = AluOpSub;
        ImmSrc       = ImmB;
        pc_write_raw = zero ^ funct3[0];
        retire_raw   = 1'b1;
        state_d      = StFetch;
      end
      StTrap: begin
        halted_raw = 1'b1;
      end
      default: state_d = StTrap;
    endcase
  end

  // Enables are forced low during reset so an aborted access commits nothing.
  assign PCWrite  = pc_write_raw & ~rst;
  assign MemWrite = mem_write_raw & ~rst;
  assign IRWrite  = ir_write_raw & ~rst;
  assign RegWrite = reg_write_raw & ~rst;
  assign retire   = retire_raw & ~rst;
  assign halted   = halted_raw & ~rst;

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7_5    (instr[30]),
    .op_5        (opcode[5]),
    .alu_control (ALUControl)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed table-driven bench for multicycle_controller plus hand sequences for
// trap hold and reset during a store.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        zero;
  logic        mem_ready;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, retire, halted;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0]  ALUControl;

  multicycle_controller dut (
    .clk        (clk),
    .rst        (rst),
    .instr      (instr),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUControl (ALUControl),
    .ImmSrc     (ImmSrc),
    .RegWrite   (RegWrite),
    .retire     (retire),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst;
    logic [31:0] instr;
    logic        zero;
    logic        mr;
    logic [17:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  // {PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUControl,ImmSrc,
  //  RegWrite,retire,halted}
  logic [17:0] act;
  assign act = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                ALUControl, ImmSrc, RegWrite, retire, halted};

  function automatic logic [17:0] mk(int pcw, int adr, int mw, int irw, int rs, int sa,
                                     int sb, int ac, int imm, int rw, int ret, int hlt);
    return {pcw[0], adr[0], mw[0], irw[0], rs[1:0], sa[1:0], sb[1:0], ac[2:0], imm[1:0],
            rw[0], ret[0], hlt[0]};
  endfunction

  task automatic check(input string name, input logic [17:0] got, input logic [17:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %b required %b", name, got, want);
    end
  endtask

  task automatic addv(input string n, input logic r, input logic [31:0] i, input logic z,
                      input logic m, input logic [17:0] e);
    vec_t v;
    v.name = n; v.rst = r; v.instr = i; v.zero = z; v.mr = m; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic [31:0] i, input logic z, input logic m);
    @(negedge clk);
    rst = r; instr = i; zero = z; mem_ready = m;
    #1;
  endtask

  logic [17:0] f1, f0, dec, wb, trp;
  localparam logic [31:0] IAdd = 32'h002081B3;
  localparam logic [31:0] ISub = 32'h402081B3;
  localparam logic [31:0] ISlt = 32'h0020A1B3;
  localparam logic [31:0] IAnd = 32'h0020F1B3;
  localparam logic [31:0] IAddi = 32'h00500093;
  localparam logic [31:0] IOri = 32'h00506093;
  localparam logic [31:0] ILw = 32'h00402283;
  localparam logic [31:0] ISw = 32'h00502223;
  localparam logic [31:0] IBeq = 32'h00000063;
  localparam logic [31:0] IBne = 32'h00001063;
  localparam logic [31:0] IJal = 32'h008000EF;
  localparam logic [31:0] IBadR = 32'h4020E1B3;
  localparam logic [31:0] IBadBr = 32'h00002063;
  localparam logic [31:0] ILb = 32'h00400283;

  initial begin
    rst = 1'b1; instr = '0; zero = 1'b0; mem_ready = 1'b1;
    f1  = mk(1, 0, 0, 1, 2, 0, 2, 0, 0, 0, 0, 0);
    f0  = mk(0, 0, 0, 0, 2, 0, 2, 0, 0, 0, 0, 0);
    dec = mk(0, 0, 0, 0, 0, 1, 1, 0, 2, 0, 0, 0);
    wb  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    trp = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    addv("reset",      1, IAdd, 0, 1, f0);
    addv("add_fetch",  0, IAdd, 0, 1, f1);
    addv("add_dec",    0, IAdd, 0, 1, dec);
    addv("add_exr",    0, IAdd, 0, 1, mk(0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0));
    addv("add_wb",     0, IAdd, 0, 1, wb);
    addv("sub_fetch",  0, ISub, 0, 1, f1);
    addv("sub_dec",    0, ISub, 0, 1, dec);
    addv("sub_exr",    0, ISub, 0, 1, mk(0, 0, 0, 0, 0, 2, 0, 1, 0, 0, 0, 0));
    addv("sub_wb",     0, ISub, 0, 1, wb);
    addv("slt_fetch",  0, ISlt, 0, 1, f1);
    addv("slt_dec",    0, ISlt, 0, 1, dec);
    addv("slt_exr",    0, ISlt, 0, 1, mk(0, 0, 0, 0, 0, 2, 0, 5, 0, 0, 0, 0));
    addv("slt_wb",     0, ISlt, 0, 1, wb);
    addv("and_fetch",  0, IAnd, 0, 1, f1);
    addv("and_dec",    0, IAnd, 0, 1, dec);
    addv("and_exr",    0, IAnd, 0, 1, mk(0, 0, 0, 0, 0, 2, 0, 2, 0, 0, 0, 0));
    addv("and_wb",     0, IAnd, 0, 1, wb);
    addv("addi_fetch", 0, IAddi, 0, 1, f1);
    addv("addi_dec",   0, IAddi, 0, 1, dec);
    addv("addi_exi",   0, IAddi, 0, 1, mk(0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0));
    addv("addi_wb",    0, IAddi, 0, 1, wb);
    addv("ori_fetch",  0, IOri, 0, 1, f1);
    addv("ori_dec",    0, IOri, 0, 1, dec);
    addv("ori_exi",    0, IOri, 0, 1, mk(0, 0, 0, 0, 0, 2, 1, 3, 0, 0, 0, 0));
    addv("ori_wb",     0, IOri, 0, 1, wb);
    addv("lw_fetch_w", 0, ILw, 0, 0, f0);
    addv("lw_fetch",   0, ILw, 0, 1, f1);
    addv("lw_dec",     0, ILw, 0, 1, dec);
    addv("lw_madr",    0, ILw, 0, 0, mk(0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0));
    addv("lw_rd0",     0, ILw, 0, 0, mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    addv("lw_rd1",     0, ILw, 0, 0, mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    addv("lw_rd2",     0, ILw, 0, 1, mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    addv("lw_memwb",   0, ILw, 0, 0, mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0));
    addv("sw_fetch",   0, ISw, 0, 1, f1);
    addv("sw_dec",     0, ISw, 0, 1, dec);
    addv("sw_madr",    0, ISw, 0, 1, mk(0, 0, 0, 0, 0, 2, 1, 0, 1, 0, 0, 0));
    addv("sw_wr0",     0, ISw, 0, 0, mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    addv("sw_wr1",     0, ISw, 0, 1, mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    addv("beq_fetch",  0, IBeq, 1, 1, f1);
    addv("beq_dec",    0, IBeq, 1, 1, dec);
    addv("beq_br_z1",  0, IBeq, 1, 1, mk(1, 0, 0, 0, 0, 2, 0, 1, 2, 0, 1, 0));
    addv("bne_fetch",  0, IBne, 1, 1, f1);
    addv("bne_dec",    0, IBne, 1, 1, dec);
    addv("bne_br_z1",  0, IBne, 1, 1, mk(0, 0, 0, 0, 0, 2, 0, 1, 2, 0, 1, 0));
    addv("bne2_fetch", 0, IBne, 0, 1, f1);
    addv("bne2_dec",   0, IBne, 0, 1, dec);
    addv("bne_br_z0",  0, IBne, 0, 1, mk(1, 0, 0, 0, 0, 2, 0, 1, 2, 0, 1, 0));
    addv("jal_fetch",  0, IJal, 0, 1, f1);
    addv("jal_dec",    0, IJal, 0, 1, dec);
    addv("jal_jal",    0, IJal, 0, 1, mk(1, 0, 0, 0, 0, 1, 2, 0, 3, 0, 0, 0));
    addv("jal_wb",     0, IJal, 0, 1, wb);
    addv("badr_fetch", 0, IBadR, 0, 1, f1);
    addv("badr_dec",   0, IBadR, 0, 1, dec);
    addv("badr_trap0", 0, IBadR, 0, 1, trp);
    addv("badr_trap1", 0, IAdd, 0, 1, trp);
    addv("badr_rst",   1, IAdd, 0, 1, f0);
    addv("badbr_fetch", 0, IBadBr, 0, 1, f1);
    addv("badbr_dec",  0, IBadBr, 0, 1, dec);
    addv("badbr_trap", 0, IBadBr, 0, 1, trp);
    addv("badbr_rst",  1, IBadBr, 0, 1, f0);
    addv("lb_fetch",   0, ILb, 0, 1, f1);
    addv("lb_dec",     0, ILb, 0, 1, dec);
    addv("lb_trap",    0, ILb, 0, 1, trp);
    addv("lb_rst",     1, ILb, 0, 1, f0);

    foreach (vecs[k]) begin
      drive(vecs[k].rst, vecs[k].instr, vecs[k].zero, vecs[k].mr);
      check(vecs[k].name, act, vecs[k].exp);
    end

    // All-zero encoding traps and stays trapped regardless of inputs.
    drive(0, 32'h0, 0, 1);
    check("zero_fetch", act, f1);
    drive(0, 32'h0, 0, 1);
    check("zero_dec", act, dec);
    for (int c = 0; c < 12; c++) begin
      drive(0, IAdd, c[0], c[1]);
      check("trap_hold", act, trp);
    end
    drive(1, IAdd, 0, 1);
    check("trap_rst", act, f0);

    // Reset raised mid-store must drop MemWrite within the same cycle.
    drive(0, ISw, 0, 1);
    check("rsw_fetch", act, f1);
    drive(0, ISw, 0, 0);
    check("rsw_dec", act, dec);
    drive(0, ISw, 0, 0);
    check("rsw_madr", act, mk(0, 0, 0, 0, 0, 2, 1, 0, 1, 0, 0, 0));
    drive(0, ISw, 0, 0);
    check("rsw_write", act, mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #2 rst = 1'b1;
    #1;
    check("rsw_abort", act, f0);
    drive(0, ISw, 0, 1);
    check("rsw_refetch", act, f1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Sequencing FSM for the multicycle RV32I core: steps the shared datapath through fetch/decode/execute/memory/writeback, one instruction at a time.
- Drives a single ALU, a unified instruction/data memory port and the register file.
- Supports ADD/SUB/SLT/OR/AND (R and I), LW, SW, BEQ, BNE and JAL.
- Enters a sticky TRAP on any other encoding.
- Sits between the instruction register and all datapath muxes and write enables.

Parameters:
- RESET_STATE, FETCH, initial FSM state after reset.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-high reset
- instr  in  32  instruction register contents, valid from DECODE onward
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- PCWrite  out  1  PC register write enable
- AdrSrc  out  1  memory address: 0=PC, 1=ALUOut
- MemWrite  out  1  memory write request
- IRWrite  out  1  instruction register and OldPC write enable
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
- ALUSrcA  out  2  00=PC, 01=OldPC, 10=rs1
- ALUSrcB  out  2  00=rs2, 01=imm, 10=constant 4
- ALUControl  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 101 SLT
- ImmSrc  out  2  00 I, 01 S, 10 B, 11 J
- RegWrite  out  1  register file write enable
- retire  out  1  one-cycle pulse when an instruction completes
- halted  out  1  FSM is in TRAP

Behaviour:
- Clock, reset and timing:
  - Single clock domain.
  - rst asserted: state=FETCH immediately (asynchronous). While rst is high, PCWrite, IRWrite, MemWrite, RegWrite, retire and halted are all 0.
  - All other outputs are Moore decodes of state, plus instr fields where noted. Unlisted outputs are 0.
- FETCH:
  - Outputs: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite=PCWrite=mem_ready.
  - Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE:
  - Outputs: ALUSrcA=01, ALUSrcB=01, ImmSrc=10, ALUOp=00.
  - Legality check:
    - R/I-type: funct3 ∈ {000,010,110,111}.
    - R-type only: funct7[5]=1 is allowed only with funct3=000.
    - LW/SW: funct3=010.
    - Branch: funct3 ∈ {000,001}.
  - Next state:
    - LW/SW → MEMADR
    - R → EXECUTER
    - I-ALU → EXECUTEI
    - JAL → JAL
    - branch → BRANCH
    - illegal or unknown opcode → TRAP
- MEMADR:
  - Outputs: ALUSrcA=10, ALUSrcB=01, ALUOp=00, ImmSrc = 00 for LW, 01 for SW.
  - Next state: MEMREAD for LW, MEMWRITE for SW.
- MEMREAD:
  - Outputs: AdrSrc=1, ResultSrc=00.
  - Hold until mem_ready, then go to MEMWB.
- MEMWB:
  - Outputs: ResultSrc=01, RegWrite=1, retire=1.
  - Next state: FETCH.
- MEMWRITE:
  - Outputs: AdrSrc=1, MemWrite=1 held while in this state.
  - On mem_ready: retire=1, go to FETCH.
- EXECUTER:
  - Outputs: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
  - Next state: ALUWB.
- EXECUTEI:
  - Outputs: ALUSrcA=10, ALUSrcB=01, ImmSrc=00, ALUOp=10.
  - Next state: ALUWB.
- ALUWB:
  - Outputs: ResultSrc=00, RegWrite=1, retire=1.
  - Next state: FETCH.
- JAL:
  - Outputs: ALUSrcA=01, ALUSrcB=10, ImmSrc=11, ResultSrc=00, PCWrite=1.
  - Next state: ALUWB.
- BRANCH:
  - Outputs: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ImmSrc=10, ResultSrc=00.
  - PCWrite = zero XOR funct3[0], so BEQ is taken on zero=1 and BNE on zero=0.
  - retire=1; next state FETCH.
- TRAP:
  - All enables 0; halted=1.
  - Leaves TRAP only on rst.
- ALU decode:
  - ALUOp=00 → ADD; ALUOp=01 → SUB.
  - ALUOp=10:
    - funct3=000: SUB if opcode[5]&funct7[5], else ADD.
    - 010 → SLT; 110 → OR; 111 → AND.
- Reset mid-operation: any state, including MEMWRITE with MemWrite high, aborts at once. No partial write is committed after rst rises.
- mem_ready outside FETCH, MEMREAD and MEMWRITE is ignored.

Decomposition:
- Shared package riscv_ctrl_pkg:
  - state enum, encoded 4-bit.
  - Opcode constants: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111.
  - ALUControl, ImmSrc, ResultSrc, ALUSrcA and ALUSrcB encodings.
  - ALUOp encoding.
- Sub-module alu_decoder: purely combinational ALUOp/funct3/funct7[5]/opcode[5] → ALUControl.
- The FSM lives in multicycle_controller.

Test Plan:
- add x3,x1,x2 (0x002081B3), mem_ready=1 → FETCH, DECODE, EXECUTER, ALUWB.
  - EXECUTER: ALUControl=000.
  - ALUWB: RegWrite=1, retire=1.
  - Back in FETCH at cycle 5.
- sub x3,x1,x2 (0x402081B3) → ALUControl=001 in EXECUTER.
  - Same instruction with funct3=110 and funct7[5]=1 → TRAP.
- lw x5,4(x0) (0x00402283), mem_ready low 2 cycles in MEMREAD → MEMREAD held 3 cycles with AdrSrc=1, then MEMWB with RegWrite=1 and ResultSrc=01.
- sw x5,4(x0) (0x00502223), mem_ready low 1 cycle → MemWrite=1 for 2 cycles in MEMWRITE, RegWrite never asserted, retire on the mem_ready cycle.
- Branch resolution:
  - beq x0,x0 (0x00000063) with zero=1 → PCWrite=1 in BRANCH.
  - bne (0x00001063) with zero=1 → PCWrite=0.
  - jal (opcode 1101111) → PCWrite=1 in JAL, RegWrite=1 in ALUWB.
- Trap and reset:
  - instr 0x00000000 → TRAP, halted=1 for 10+ cycles.
  - rst pulse → FETCH, halted=0.
  - Separately, rst asserted mid-MEMWRITE → MemWrite=0 in the same cycle.
